// File: rtl/shift_pipe_pkg.sv
// Shared helpers for the parametrised shift pipe.
// Holds derived-width math and reset defaults.
package shift_pipe_pkg;

  localparam bit ZERO_DATA = 1'b0;

  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One enabled pipe stage: data plus valid.
// Flush clears valid only; data still follows en.
import shift_pipe_pkg::*;

module shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q  <= {WIDTH{ZERO_DATA}};
      valid_q <= 1'b0;
    end else begin
      if (en) data_q <= d_i;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (en) begin
        valid_q <= v_i;
      end
    end
  end

  assign q_o = data_q;
  assign v_o = valid_q;

endmodule

// File: rtl/param_shift_pipe.sv
// WIDTH x DEPTH delay line with valid tracking,
// flush, clamped runtime tap and occupancy count.
import shift_pipe_pkg::*;

module param_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int TAP_W = safe_clog2(DEPTH),
  parameter int CNT_W = safe_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] tap_dout,
  output logic             tap_valid,
  output logic [CNT_W-1:0] fill_cnt
);

  logic [WIDTH-1:0] chain_d  [DEPTH];
  logic [DEPTH-1:0] chain_v;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] stg_valid;

  assign chain_d[0] = din;
  assign chain_v[0] = din_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign chain_d[k] = stg_data[k-1];
      assign chain_v[k] = stg_valid[k-1];
    end
    shift_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .resetn(resetn),
      .en    (en),
      .flush (flush),
      .d_i   (chain_d[k]),
      .v_i   (chain_v[k]),
      .q_o   (stg_data[k]),
      .v_o   (stg_valid[k])
    );
  end

  assign dout       = stg_data[DEPTH-1];
  assign dout_valid = stg_valid[DEPTH-1];

  // Out-of-range selects fall through to the last stage.
  always_comb begin
    tap_dout  = stg_data[DEPTH-1];
    tap_valid = stg_valid[DEPTH-1];
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (tap_sel == TAP_W'(k)) begin
        tap_dout  = stg_data[k];
        tap_valid = stg_valid[k];
      end
    end
  end

  if (DEPTH == 1) begin : g_no_tap
    logic unused_tap;
    assign unused_tap = ^tap_sel;
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(din_valid)
            - CNT_W'(stg_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign fill_cnt = cnt_q;

  a_fill_matches: assert property (
    @(posedge clk) disable iff (!resetn)
    int'(cnt_q) == $countones(stg_valid)
  );

endmodule

// File: tb/tb_param_shift_pipe.sv
// Bench for param_shift_pipe (WIDTH=8, DEPTH=3).
// Slot-array reference model plus directed scenarios.
module tb_param_shift_pipe;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         resetn;
  logic         en;
  logic         flush;
  logic [W-1:0] din;
  logic         din_valid;
  logic [1:0]   tap_sel;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic [W-1:0] tap_dout;
  logic         tap_valid;
  logic [1:0]   fill_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] md [D];
  bit           mv [D];

  always #5 clk = ~clk;

  param_shift_pipe #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .flush     (flush),
    .din       (din),
    .din_valid (din_valid),
    .tap_sel   (tap_sel),
    .dout      (dout),
    .dout_valid(dout_valid),
    .tap_dout  (tap_dout),
    .tap_valid (tap_valid),
    .fill_cnt  (fill_cnt)
  );

  function automatic int occupancy();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(mv[k]);
    return n;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      md[k] = '0;
      mv[k] = 1'b0;
    end
  endtask

  // Apply inputs, take one edge, update model, settle.
  task automatic tick(input bit e, input bit f,
                      input logic [W-1:0] d,
                      input bit v);
    en = e; flush = f; din = d; din_valid = v;
    @(posedge clk);
    if (e) begin
      for (int k = D - 1; k > 0; k--) begin
        md[k] = md[k-1];
        mv[k] = mv[k-1];
      end
      md[0] = d;
      mv[0] = v;
    end
    if (f) for (int k = 0; k < D; k++) mv[k] = 1'b0;
    #1;
  endtask

  task automatic empty_and_fill();
    tick(0, 1, 8'h00, 0);
    tick(1, 0, 8'hA1, 1);
    tick(1, 0, 8'hB2, 1);
    tick(1, 0, 8'hC3, 1);
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 0; flush = 0;
    din = '0; din_valid = 0; tap_sel = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dout, dout_valid, tap_dout, tap_valid, fill_cnt}
        !== '0) begin
      errors++;
      $display("FAIL reset_init got %h/%b/%h/%b/%0d want 0",
               dout, dout_valid, tap_dout, tap_valid, fill_cnt);
    end
    resetn = 1'b1;
    empty_and_fill();
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({dout, dout_valid, tap_dout, tap_valid, fill_cnt}
        !== '0) begin
      errors++;
      $display("FAIL reset_async got %h/%b/%h/%b/%0d want 0",
               dout, dout_valid, tap_dout, tap_valid, fill_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick(0, 0, 8'h00, 0);
  endtask

  task automatic test_latency();
    logic [W-1:0] exp_d [5];
    int           exp_c [5];
    bit           exp_v [5];
    exp_d = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3};
    exp_v = '{0, 0, 1, 1, 1};
    exp_c = '{1, 2, 3, 3, 2};
    tick(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: tick(1, 0, 8'hA1, 1);
        1: tick(1, 0, 8'hB2, 1);
        2: tick(1, 0, 8'hC3, 1);
        3: tick(1, 0, 8'hD4, 1);
        default: tick(1, 0, 8'hE5, 0);
      endcase
      checks++;
      if (dout_valid !== exp_v[i] ||
          (exp_v[i] && dout !== exp_d[i]) ||
          int'(fill_cnt) != exp_c[i]) begin
        errors++;
        $display("FAIL latency_%0d got %h/%b/%0d want %h/%b/%0d",
                 i, dout, dout_valid, fill_cnt,
                 exp_d[i], exp_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_d [2];
    exp_d = '{8'hB2, 8'hC3};
    empty_and_fill();
    tap_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, W'($urandom), 1'($urandom));
      checks++;
      if (dout !== 8'hA1 || !dout_valid ||
          tap_dout !== 8'hB2 || fill_cnt !== 2'd3) begin
        errors++;
        $display("FAIL stall_%0d got %h/%h/%0d want a1/b2/3",
                 i, dout, tap_dout, fill_cnt);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 8'h00, 0);
      checks++;
      if (dout !== exp_d[i] || !dout_valid) begin
        errors++;
        $display("FAIL resume_%0d got %h/%b want %h/1",
                 i, dout, dout_valid, exp_d[i]);
      end
    end
  endtask

  task automatic test_tap();
    logic [W-1:0] exp_d [4];
    exp_d = '{8'hC3, 8'hB2, 8'hA1, 8'hA1};
    empty_and_fill();
    for (int s = 0; s < 4; s++) begin
      tap_sel = 2'(s);
      #1;
      checks++;
      if (tap_dout !== exp_d[s] || !tap_valid) begin
        errors++;
        $display("FAIL tap_%0d got %h/%b want %h/1",
                 s, tap_dout, tap_valid, exp_d[s]);
      end
    end
  endtask

  task automatic test_flush();
    empty_and_fill();
    tap_sel = 2'd0;
    tick(1, 1, 8'h55, 1);
    checks++;
    if (fill_cnt !== 2'd0 || dout_valid || tap_valid ||
        tap_dout !== 8'h55 || dout !== 8'hB2) begin
      errors++;
      $display("FAIL flush_en got cnt%0d dv%b tv%b t%h d%h",
               fill_cnt, dout_valid, tap_valid, tap_dout, dout);
    end
  endtask

  task automatic test_bubbles();
    bit pat [7];
    pat = '{1, 0, 1, 0, 0, 0, 0};
    tick(0, 1, 8'h00, 0);
    for (int i = 0; i < 7; i++) begin
      tick(1, 0, 8'h10 + 8'(i), pat[i]);
      checks++;
      if (dout_valid !== (i >= 2 ? pat[i-2] : 1'b0) ||
          int'(fill_cnt) != occupancy() ||
          fill_cnt > 2'd2) begin
        errors++;
        $display("FAIL bubble_%0d got dv%b cnt%0d want cnt%0d",
                 i, dout_valid, fill_cnt, occupancy());
      end
    end
  endtask

  task automatic test_random();
    int idx;
    for (int i = 0; i < 300; i++) begin
      tap_sel = 2'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 15) == 0,
           W'($urandom), 1'($urandom));
      idx = (int'(tap_sel) >= D) ? D - 1 : int'(tap_sel);
      checks++;
      if (dout_valid !== mv[D-1] ||
          (mv[D-1] && dout !== md[D-1]) ||
          tap_valid !== mv[idx] ||
          (mv[idx] && tap_dout !== md[idx]) ||
          int'(fill_cnt) != occupancy()) begin
        errors++;
        $display("FAIL rand_%0d got %h/%b %h/%b %0d want %h/%b %h/%b %0d",
                 i, dout, dout_valid, tap_dout, tap_valid,
                 fill_cnt, md[D-1], mv[D-1], md[idx], mv[idx],
                 occupancy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_tap();
    test_flush();
    test_bubbles();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
